// File: rtl/moddiv29_pkg.sv
// Shared constants and types for the GF(29) divider: modulus, Fermat exponent,
// FSM states and the fixed square/multiply schedule.
package moddiv29_pkg;

    localparam logic [4:0] MOD = 5'd29;
    localparam logic [4:0] EXP = 5'd27;

    // Bits 3..0 of EXP as S,M,S,S,M,S,M (step 0 at bit 0); 1 = multiply by br, 0 = square.
    localparam logic [6:0] SCHED = 7'b1010010;
    localparam logic [2:0] LAST_STEP = 3'd6;

    typedef enum logic [1:0] {
        StIdle,
        StExp,
        StFin,
        StDone
    } state_e;

    function automatic logic [4:0] reduce5(input logic [4:0] v);
        return (v >= MOD) ? v - MOD : v;
    endfunction

endpackage

// File: rtl/moddiv29_if.sv
// Operand/result handshake bundle for moddiv29.
interface moddiv29_if;

    logic       in_valid;
    logic       in_ready;
    logic [4:0] a;
    logic [4:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] q;
    logic       err;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, err
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, err
    );

endinterface

// File: rtl/moddiv29_gf29_mul.sv
// Combinational x*y mod 29 for operands already in 0..28.
module gf29_mul
    import moddiv29_pkg::*;
(
    input  logic [4:0] x,
    input  logic [4:0] y,
    output logic [4:0] z
);

    logic [9:0] w_p;
    logic [6:0] w_f1;
    logic [5:0] w_f2;

    // 32 = 3 mod 29: fold the bits above 2^5 back in twice (max 40), then one subtract.
    assign w_p  = {5'b0, x} * {5'b0, y};
    assign w_f1 = {2'b0, w_p[9:5]} * 7'd3 + {2'b0, w_p[4:0]};
    assign w_f2 = {4'b0, w_f1[6:5]} * 6'd3 + {1'b0, w_f1[4:0]};

    always_comb begin
        z = w_f2[4:0];
        if (w_f2 >= {1'b0, MOD}) begin
            z = w_f2[4:0] - MOD;
        end
    end

endmodule

// File: rtl/moddiv29.sv
// Constant-time GF(29) divider: q = a * b^27 mod 29 using one shared multiplier,
// 8 cycles from accept to out_valid for every operand pair.
module moddiv29
(
    input  logic      clk,
    input  logic      reset,
    moddiv29_if.slave bus
);

    import moddiv29_pkg::*;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [4:0] r_ar;
    logic [4:0] r_br;
    logic [4:0] r_r;
    logic [4:0] r_q;
    logic [2:0] r_step;
    logic       r_err;
    logic       r_out_valid;

    logic [4:0] w_a_red;
    logic [4:0] w_b_red;
    logic [4:0] w_x;
    logic [4:0] w_y;
    logic [4:0] w_z;
    logic       w_accept;
    logic       w_release;

    assign w_a_red   = reduce5(bus.a);
    assign w_b_red   = reduce5(bus.b);
    assign w_accept  = bus.in_valid && (r_state == StIdle);
    assign w_release = r_out_valid && bus.out_ready;

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = r_out_valid;
    assign bus.q         = r_q;
    assign bus.err       = r_err;

    gf29_mul u_mul (
        .x (w_x),
        .y (w_y),
        .z (w_z)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_x         = r_r;
        w_y         = r_r;
        unique case (r_state)
            StIdle: if (w_accept) w_state_nxt = StExp;
            StExp: begin
                if (SCHED[r_step]) w_y = r_br;
                if (r_step == LAST_STEP) w_state_nxt = StFin;
            end
            StFin: begin
                w_y         = r_ar;
                w_state_nxt = StDone;
            end
            StDone: if (w_release) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ar        <= '0;
            r_br        <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_step      <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_ar   <= w_a_red;
                        r_br   <= w_b_red;
                        // Exponent MSB is consumed here, leaving bits 3..0 for the schedule.
                        r_r    <= EXP[4] ? w_b_red : 5'd1;
                        r_step <= '0;
                    end
                end
                StExp: begin
                    r_r    <= w_z;
                    r_step <= r_step + 3'd1;
                end
                StFin: begin
                    r_q         <= w_z;
                    r_err       <= (r_br == 5'd0);
                    r_out_valid <= 1'b1;
                end
                StDone: if (w_release) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_moddiv29.sv
// Self-checking bench for moddiv29: directed cases, backpressure, mid-op reset and a
// full a/b sweep against a brute-force modular-inverse reference.
module tb_moddiv29;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_vec  = 0;
    int   n_fail = 0;

    moddiv29_if bus ();

    moddiv29 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Quotient by search: the q in 0..28 whose product with b is a, all mod 29.
    function automatic int ref_q(input int a, input int b);
        int ar = a % 29;
        int br = b % 29;
        if (br == 0) return 0;
        for (int q = 0; q < 29; q++) begin
            if ((q * br) % 29 == ar) return q;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int a, input int b, input int stall, input bit poke);
        int cyc;
        int eq;
        int ee;
        eq  = ref_q(a, b);
        ee  = ((b % 29) == 0) ? 1 : 0;
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("in_ready_idle", 32'(bus.in_ready), 1);
        bus.a        = a[4:0];
        bus.b        = b[4:0];
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~a[4:0];
        bus.b        = ~b[4:0];
        check("in_ready_busy", 32'(bus.in_ready), 0);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("latency", cyc, 8);
        check("q", 32'(bus.q), eq);
        check("err", 32'(bus.err), ee);
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.a        = 5'd4;
                bus.b        = 5'd9;
            end
            tick();
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_q", 32'(bus.q), eq);
            check("hold_err", 32'(bus.err), ee);
            check("hold_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("released_valid", 32'(bus.out_valid), 0);
        check("released_in_ready", 32'(bus.in_ready), 1);
    endtask

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        #3;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_q", 32'(bus.q), 0);
        check("rst_err", 32'(bus.err), 0);
        #4 reset = 1'b1;
        tick();
        check("in_ready_after_reset", 32'(bus.in_ready), 1);

        do_op(1, 2, 0, 1'b0);
        check("q_1_div_2", 32'(bus.q), 15);
        do_op(5, 3, 0, 1'b0);
        check("q_5_div_3", 32'(bus.q), 21);
        do_op(3, 28, 0, 1'b0);
        check("q_3_div_28", 32'(bus.q), 26);
        do_op(31, 30, 0, 1'b0);
        check("q_31_div_30", 32'(bus.q), 2);
        do_op(7, 29, 0, 1'b0);
        check("err_b29", 32'(bus.err), 1);

        // Backpressure with ignored operands presented while busy.
        do_op(11, 6, 5, 1'b1);
        tick();
        tick();
        check("poke_ignored_valid", 32'(bus.out_valid), 0);
        check("poke_ignored_ready", 32'(bus.in_ready), 1);

        // Abort mid-operation; q currently holds a nonzero earlier result.
        do_op(9, 5, 0, 1'b0);
        bus.a        = 5'd9;
        bus.b        = 5'd5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 0);
        check("abort_q", 32'(bus.q), 0);
        check("abort_err", 32'(bus.err), 0);
        check("abort_in_ready", 32'(bus.in_ready), 1);
        #3 reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen = 1;
        end
        check("abort_no_result", seen, 0);
        do_op(2, 2, 0, 1'b0);
        check("q_2_div_2", 32'(bus.q), 1);

        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                do_op(a, b, int'($urandom_range(0, 2)), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/moddiv29.md
Name: moddiv29

Overview:
- Sequential modular divider over GF(29): computes q = a * b^-1 mod 29, the inverse operation of the existing 5-bit mod-29 multiplier.
- The inverse is computed by Fermat exponentiation: b^-1 = b^27 mod 29, using fixed left-to-right square-and-multiply.
- One shared combinational mod-29 multiplier is used once per cycle.
- Constant-time datapath for side-channel-sensitive use: latency is independent of operand values, including b = 0.

Parameters:
- None. The modulus (29) and exponent (27) are fixed constants in the shared package.

Ports:
- clk        input   1  clock, rising edge
- reset      input   1  asynchronous, active-low reset
- in_valid   input   1  operands a, b presented
- in_ready   output  1  block idle; can accept operands
- a          input   5  dividend, any value 0..31
- b          input   5  divisor, any value 0..31
- out_valid  output  1  result q and err available
- out_ready  input   1  consumer accepts result
- q          output  5  quotient, always in range 0..28
- err        output  1  divisor reduced to 0; q forced to 0

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE, out_valid = 0, q = 0, err = 0, internal registers = 0.
- in_ready = (state == IDLE); it is combinational from state, so it is 1 from the first cycle after reset release.
- Operand reduction on capture: values 29, 30, 31 map to 0, 1, 2; values 0..28 pass unchanged. The reduced values are stored in registers ar and br.
- Accept edge E0: in_valid & in_ready. Action: capture ar, br; r <= br (covers exponent bit 4); step <= 0; state <= EXP.
- EXP state, one multiply per cycle at edges E1..E7. Fixed schedule for exponent 27 = 5'b11011, bits 3..0:
  - S, M, S, S, M, S, M
  - S: r <= r*r mod 29
  - M: r <= r*br mod 29
  - step counts 0..6 and is decoded from a package constant. After step 6, state <= FIN.
- FIN state, edge E8: q <= r*ar mod 29; err <= (br == 0); out_valid <= 1; state <= DONE.
- DONE state: q, err, out_valid held stable. On out_valid & out_ready, out_valid <= 0 and state <= IDLE.
- A new operand is accepted no earlier than the cycle after the handshake (in_ready goes high one cycle after out_ready). Throughput is 1 result per 10 cycles minimum.
- Latency: out_valid rises exactly 8 clocks after the accept edge, regardless of operand values.
- b == 0 after reduction: the schedule runs unchanged (b^27 = 0, so q = 0 naturally); err = 1. There is no early exit.
- a == 0 after reduction: q = 0, err = 0.
- in_valid while busy is ignored; a and b are not sampled.
- out_ready while out_valid = 0 has no effect.
- Reset asserted mid-operation: immediate abort, all registers return to reset values, no out_valid pulse.
- Arithmetic: every product is a 10-bit unsigned value reduced to 0..28 by the sub-module. All stored values stay in 0..28.

Decomposition:
- Package moddiv29_pkg holds:
  - MOD = 5'd29
  - EXP = 5'd27
  - state enum: IDLE, EXP, FIN, DONE
  - SCHED: 7-entry bit vector, 1 = multiply, 0 = square, value S M S S M S M
- Sub-module gf29_mul (combinational): inputs x[4:0], y[4:0] in 0..28; output z[4:0] = x*y mod 29.
  - Reduction uses 32 ≡ 3 (mod 29): fold the high part twice, then one conditional subtract of 29.
  - It is instantiated once; its operands are muxed from r, br, ar by state and step.

Test Plan:
- Reset release, then a=1, b=2, out_ready=1 -> in_ready=1 before accept; out_valid exactly 8 cycles after accept; q=15, err=0.
- a=5, b=3 -> q=21, err=0. a=3, b=28 -> q=26, err=0.
- Unreduced inputs: a=31, b=30 (reduced to 2 and 1) -> q=2, err=0. a=7, b=29 (b reduces to 0) -> q=0, err=1, still 8-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> q, err, out_valid stable; in_ready=0 throughout. in_valid pulsed with new operands meanwhile -> ignored. Release -> in_ready=1 the next cycle.
- Reset pulsed at cycle 4 of an operation -> out_valid, q, err = 0 immediately; no result appears; the next operation a=2, b=2 -> q=1.
- Exhaustive sweep of a, b over 0..31 with random out_ready stalls -> (q*b_red) mod 29 == a_red for every b_red ≠ 0; q=0 and err=1 for every b_red = 0.
